// File: rtl/mrmw_rdata.sv
// mrmw_rdata: multi-write-port, multi-read-port word memory with registered
// read data and a one-cycle read-valid flag.
// Optional feature: define MRMW_RDATA_WSTRB_EN to add per-byte write strobes
// (port wstrb). Without it, every write replaces the whole word.
// Same-address writes resolve toward the highest-indexed write port.
// READ_FIRST selects whether a colliding read sees the old or the new word.
module mrmw_rdata #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_WR     = 2,
  parameter int NUM_RD     = 2,
  parameter int READ_FIRST = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_WR-1:0]              wen,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]   waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   wdata,
`ifdef MRMW_RDATA_WSTRB_EN
  input  logic [NUM_WR*DATA_WIDTH/8-1:0] wstrb,
`endif
  input  logic [NUM_RD-1:0]              ren,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rdata,
  output logic [NUM_RD-1:0]              rvalid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef MRMW_RDATA_WSTRB_EN
  localparam int NB = DATA_WIDTH / 8;
`endif

  // Storage is deliberately outside the reset domain: contents survive reset.
  logic [DATA_WIDTH-1:0] r_mem     [DEPTH];
  logic [DATA_WIDTH-1:0] w_mem_nxt [DEPTH];
  logic [DATA_WIDTH-1:0] w_rd_word [NUM_RD];

  logic [NUM_RD*DATA_WIDTH-1:0] r_rdata;
  logic [NUM_RD-1:0]            r_rvalid;

  // Post-write image of the memory; later ports overwrite earlier ones, so
  // the highest-indexed port wins each byte (or word) it writes.
  always_comb begin
    w_mem_nxt = r_mem;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wen[i]) begin
`ifdef MRMW_RDATA_WSTRB_EN
        for (int b = 0; b < NB; b++) begin
          if (wstrb[i*NB + b]) begin
            w_mem_nxt[waddr[i*ADDR_WIDTH +: ADDR_WIDTH]][b*8 +: 8] =
              wdata[i*DATA_WIDTH + b*8 +: 8];
          end
        end
`else
        w_mem_nxt[waddr[i*ADDR_WIDTH +: ADDR_WIDTH]] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
`endif
      end
    end
  end

  // Read word per port: pre-write array for read-first, resolved image otherwise.
  always_comb begin
    for (int j = 0; j < NUM_RD; j++) begin
      if (READ_FIRST != 0) begin
        w_rd_word[j] = r_mem[raddr[j*ADDR_WIDTH +: ADDR_WIDTH]];
      end else begin
        w_rd_word[j] = w_mem_nxt[raddr[j*ADDR_WIDTH +: ADDR_WIDTH]];
      end
    end
  end

  // Memory update; writes keep landing even while rst_n is low.
  always_ff @(posedge clk) begin
    r_mem <= w_mem_nxt;
  end

  // Read registers: cleared asynchronously, load on enable, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= '0;
    end else begin
      r_rvalid <= ren;
      for (int j = 0; j < NUM_RD; j++) begin
        if (ren[j]) begin
          r_rdata[j*DATA_WIDTH +: DATA_WIDTH] <= w_rd_word[j];
        end
      end
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;

endmodule

// File: tb/tb_mrmw_rdata.sv
// Bench for mrmw_rdata: a read-first and a write-first instance share the
// same stimulus. Directed steps carry hand-computed expectations; the
// random phase uses a small behavioural model. Expected outputs go into a
// queue and a monitor compares them against the DUTs on every falling edge.
module tb_mrmw_rdata;

  logic        clk;
  logic        rst_n;
  logic [1:0]  wen;
  logic [3:0]  waddr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic [1:0]  ren;
  logic [3:0]  raddr;
  logic [63:0] rdata_rf, rdata_wf;
  logic [1:0]  rvalid_rf, rvalid_wf;

  typedef struct {
    string       nm;
    logic [1:0]  rv;
    logic [31:0] rf0, rf1, wf0, wf1;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // behavioural model state
  logic [31:0] m_mem [4];
  logic [31:0] m_rf  [2];
  logic [31:0] m_wf  [2];
  logic [1:0]  m_rv;

  mrmw_rdata #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .NUM_WR(2), .NUM_RD(2), .READ_FIRST(1)) u_dut_rf (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
`ifdef MRMW_RDATA_WSTRB_EN
    .wstrb(wstrb),
`endif
    .ren(ren), .raddr(raddr), .rdata(rdata_rf), .rvalid(rvalid_rf)
  );

  mrmw_rdata #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .NUM_WR(2), .NUM_RD(2), .READ_FIRST(0)) u_dut_wf (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
`ifdef MRMW_RDATA_WSTRB_EN
    .wstrb(wstrb),
`endif
    .ren(ren), .raddr(raddr), .rdata(rdata_wf), .rvalid(rvalid_wf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
  endtask

  // monitor: one expected record per cycle, compared on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.nm, " rvalid_rf"}, {30'b0, rvalid_rf}, {30'b0, e.rv});
        chk({e.nm, " rvalid_wf"}, {30'b0, rvalid_wf}, {30'b0, e.rv});
        chk({e.nm, " rdata_rf[0]"}, rdata_rf[31:0],  e.rf0);
        chk({e.nm, " rdata_rf[1]"}, rdata_rf[63:32], e.rf1);
        chk({e.nm, " rdata_wf[0]"}, rdata_wf[31:0],  e.wf0);
        chk({e.nm, " rdata_wf[1]"}, rdata_wf[63:32], e.wf1);
      end
    end
  end

  // One clock of stimulus. glitch pulses rst_n low between edges.
  task automatic step(input string nm, input logic rst, input logic glitch,
                      input logic [1:0] we, input logic [1:0] wa0, input logic [1:0] wa1,
                      input logic [31:0] wd0, input logic [31:0] wd1, input logic [7:0] ws,
                      input logic [1:0] re, input logic [1:0] ra0, input logic [1:0] ra1,
                      input logic hand, input logic [1:0] hrv,
                      input logic [31:0] hrf0, input logic [31:0] hrf1,
                      input logic [31:0] hwf0, input logic [31:0] hwf1);
    logic [31:0] mn [4];
    logic [1:0]  a;
    logic [31:0] d;
    logic [1:0]  ra;
    exp_t        e;
    @(negedge clk);
    #1;
    rst_n = rst;
    wen   = we;
    waddr = {wa1, wa0};
    wdata = {wd1, wd0};
    wstrb = ws;
    ren   = re;
    raddr = {ra1, ra0};
    if (glitch) begin
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      m_rv = 2'b00;
      for (int j = 0; j < 2; j++) begin
        m_rf[j] = '0;
        m_wf[j] = '0;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) mn[k] = m_mem[k];
    for (int i = 0; i < 2; i++) begin
      if (we[i]) begin
        a = (i == 0) ? wa0 : wa1;
        d = (i == 0) ? wd0 : wd1;
`ifdef MRMW_RDATA_WSTRB_EN
        for (int b = 0; b < 4; b++)
          if (ws[i*4 + b]) mn[a][b*8 +: 8] = d[b*8 +: 8];
`else
        mn[a] = d;
`endif
      end
    end
    for (int j = 0; j < 2; j++) begin
      ra = (j == 0) ? ra0 : ra1;
      if (!rst) begin
        m_rv[j] = 1'b0;
        m_rf[j] = '0;
        m_wf[j] = '0;
      end else begin
        m_rv[j] = re[j];
        if (re[j]) begin
          m_rf[j] = m_mem[ra];
          m_wf[j] = mn[ra];
        end
      end
    end
    for (int k = 0; k < 4; k++) m_mem[k] = mn[k];
    e.nm = nm;
    if (hand) begin
      e.rv = hrv; e.rf0 = hrf0; e.rf1 = hrf1; e.wf0 = hwf0; e.wf1 = hwf1;
    end else begin
      e.rv = m_rv; e.rf0 = m_rf[0]; e.rf1 = m_rf[1]; e.wf0 = m_wf[0]; e.wf1 = m_wf[1];
    end
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; wen = '0; waddr = '0; wdata = '0; wstrb = 8'hFF; ren = '0; raddr = '0;
    m_rv = '0;
    for (int k = 0; k < 4; k++) m_mem[k] = '0;
    for (int j = 0; j < 2; j++) begin m_rf[j] = '0; m_wf[j] = '0; end

    // name                rst g  we    wa0 wa1 wd0           wd1           ws     re    ra0 ra1 h  rv     rf0           rf1           wf0           wf1
    step("reset_read",      0, 0, 2'b01, 0, 0, 32'h0,         32'h0,        8'hFF, 2'b11, 1, 1, 1, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0);
    step("write_a1",        1, 0, 2'b01, 1, 0, 32'hDEADBEEF,  32'h0,        8'hFF, 2'b00, 0, 0, 1, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0);
    step("read_a1",         1, 0, 2'b00, 0, 0, 32'h0,         32'h0,        8'hFF, 2'b01, 1, 0, 1, 2'b01, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0);
    step("dual_write_a2",   1, 0, 2'b11, 2, 2, 32'h11111111,  32'h22222222, 8'hFF, 2'b00, 0, 0, 1, 2'b00, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0);
    step("both_read_a2",    1, 0, 2'b00, 0, 0, 32'h0,         32'h0,        8'hFF, 2'b11, 2, 2, 1, 2'b11, 32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222);
    step("write_a3",        1, 0, 2'b01, 3, 0, 32'hAAAAAAAA,  32'h0,        8'hFF, 2'b00, 0, 0, 1, 2'b00, 32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222);
    step("rw_collide_a3",   1, 0, 2'b10, 0, 3, 32'h0,         32'h55555555, 8'hFF, 2'b11, 3, 1, 1, 2'b11, 32'hAAAAAAAA, 32'hDEADBEEF, 32'h55555555, 32'hDEADBEEF);
    step("ww_rw_collide",   1, 0, 2'b11, 2, 2, 32'h12345678,  32'h9ABCDEF0, 8'hFF, 2'b01, 2, 0, 1, 2'b01, 32'h22222222, 32'hDEADBEEF, 32'h9ABCDEF0, 32'hDEADBEEF);
    step("read_a1_again",   1, 0, 2'b00, 0, 0, 32'h0,         32'h0,        8'hFF, 2'b01, 1, 0, 1, 2'b01, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    for (int k = 0; k < 10; k++)
      step("hold_idle",     1, 0, 2'b01, 1, 0, 32'hC0000000 + k, 32'h0,     8'hFF, 2'b00, 0, 0, 1, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    step("read_after_hold", 1, 0, 2'b00, 0, 0, 32'h0,         32'h0,        8'hFF, 2'b01, 1, 0, 1, 2'b01, 32'hC0000009, 32'hDEADBEEF, 32'hC0000009, 32'hDEADBEEF);
    step("async_glitch",    1, 1, 2'b00, 0, 0, 32'h0,         32'h0,        8'hFF, 2'b00, 0, 0, 1, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0);
    step("read_a2",         1, 0, 2'b00, 0, 0, 32'h0,         32'h0,        8'hFF, 2'b11, 2, 2, 1, 2'b11, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'h9ABCDEF0);
    step("reset_mid_read",  0, 0, 2'b00, 0, 0, 32'h0,         32'h0,        8'hFF, 2'b11, 2, 2, 1, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0);
    step("post_reset_idle", 1, 0, 2'b00, 0, 0, 32'h0,         32'h0,        8'hFF, 2'b00, 0, 0, 1, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0);
    step("first_read",      1, 0, 2'b00, 0, 0, 32'h0,         32'h0,        8'hFF, 2'b10, 0, 3, 1, 2'b10, 32'h0,        32'h55555555, 32'h0,        32'h55555555);
    step("read_reset_wr",   1, 0, 2'b00, 0, 0, 32'h0,         32'h0,        8'hFF, 2'b01, 0, 0, 1, 2'b01, 32'h0,        32'h55555555, 32'h0,        32'h55555555);
`ifdef MRMW_RDATA_WSTRB_EN
    step("strb_write",      1, 0, 2'b01, 0, 0, 32'hFFFFFFFF,  32'h0,        8'h05, 2'b00, 0, 0, 1, 2'b00, 32'h0,        32'h55555555, 32'h0,        32'h55555555);
    step("strb_collide",    1, 0, 2'b11, 0, 0, 32'hAAAAAAAA,  32'hBBBBBBBB, 8'h63, 2'b01, 0, 0, 1, 2'b01, 32'h00FF00FF, 32'h55555555, 32'h00BBBBAA, 32'h55555555);
    step("strb_read",       1, 0, 2'b00, 0, 0, 32'h0,         32'h0,        8'hFF, 2'b01, 0, 0, 1, 2'b01, 32'h00BBBBAA, 32'h55555555, 32'h00BBBBAA, 32'h55555555);
`endif

    // randomised phase (500 cycles = 5000 ns) against the model
    for (int n = 0; n < 500; n++) begin
      step("random", ($urandom_range(15) != 0), 0,
           2'($urandom_range(3)), 2'($urandom_range(3)), 2'($urandom_range(3)),
           $urandom, $urandom, 8'($urandom_range(255)),
           2'($urandom_range(3)), 2'($urandom_range(3)), 2'($urandom_range(3)),
           0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain pending=%0d expected=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mrmw_rdata.md
MRMW_RDATA -- requirements
Module: mrmw_rdata

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bits per memory word.
REQ-002 Parameter ADDR_WIDTH, default 2: address bits; depth = 2**ADDR_WIDTH words.
REQ-003 Parameter NUM_WR, default 2: number of write ports.
REQ-004 Parameter NUM_RD, default 2: number of read ports.
REQ-005 Parameter READ_FIRST, default 1: 1 = same-address read returns old word; 0 = returns newly written word.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 wen  input  NUM_WR  per-port write enable; bit i belongs to write port i.
REQ-009 waddr  input  NUM_WR*ADDR_WIDTH  write addresses, port i at slice i.
REQ-010 wdata  input  NUM_WR*DATA_WIDTH  write data, port i at slice i.
REQ-011 wstrb  input  NUM_WR*DATA_WIDTH/8  byte strobes, port i at slice i; present only with MRMW_RDATA_WSTRB_EN.
REQ-012 ren  input  NUM_RD  per-port read enable.
REQ-013 raddr  input  NUM_RD*ADDR_WIDTH  read addresses, port j at slice j.
REQ-014 rdata  output  NUM_RD*DATA_WIDTH  registered read data, port j at slice j.
REQ-015 rvalid  output  NUM_RD  high for exactly the cycle after an accepted read on port j.

Function
REQ-016 Read latency SHALL be one cycle: ren[j]=1 at edge N loads rdata[j] from mem[raddr[j]] at edge N; the value is visible after edge N.
REQ-017 With ren[j]=0, rdata[j] SHALL hold its previous value indefinitely, and rvalid[j] SHALL be 0 in the following cycle.
REQ-018 A write on port i with wen[i]=1 SHALL update mem[waddr[i]] at the rising edge.
REQ-019 When several write ports target the same address in one cycle, the highest-indexed port SHALL win for each written byte (per word without strobes).
REQ-020 For a read and a write to the same address in one cycle, READ_FIRST=1 SHALL return the pre-write word and READ_FIRST=0 SHALL return the post-write word after REQ-019 resolution.
REQ-021 Read ports SHALL be fully independent; any number of ports may read the same address in one cycle.
REQ-022 Addresses SHALL be used modulo depth with no out-of-range condition; ADDR_WIDTH=1 and NUM_WR=NUM_RD=1 SHALL be legal.
REQ-023 Memory contents SHALL NOT be affected by reset, and the initial contents SHALL be undefined.
REQ-024 DATA_WIDTH SHALL be a multiple of 8 when MRMW_RDATA_WSTRB_EN is defined.

Reset
REQ-025 While rst_n=0, rdata SHALL be all zeros and rvalid SHALL be all zeros, cleared asynchronously.
REQ-026 While rst_n=0, reads SHALL be ignored, but writes SHALL still update memory.
REQ-027 On the first edge after rst_n rises, REQ-016 SHALL apply normally; reset asserted mid-read SHALL discard that read.

Configuration
REQ-028 With MRMW_RDATA_WSTRB_EN defined, port wstrb SHALL exist and a write SHALL update only the bytes whose strobe bit is 1.
REQ-029 Without MRMW_RDATA_WSTRB_EN, port wstrb SHALL be absent and every write SHALL update the full word.

Verification
REQ-030 rst_n=0, ren=all ones -> rdata=0 and rvalid=0; release, then write 0xDEADBEEF to addr 1 via port 0 and read addr 1 next cycle -> rdata[0]=0xDEADBEEF, rvalid[0]=1.
REQ-031 Ports 0 and 1 write addr 2 with 0x11111111 and 0x22222222 in the same cycle, then read -> 0x22222222.
REQ-032 mem[3]=0xAAAAAAAA; write 0x55555555 to addr 3 while reading addr 3 -> 0xAAAAAAAA with READ_FIRST=1, 0x55555555 with READ_FIRST=0.
REQ-033 Read addr 1 once, then hold ren=0 for 10 cycles while writing addr 1 -> rdata holds old value, rvalid=0.
REQ-034 With WSTRB_EN, mem[0]=0x00000000, write 0xFFFFFFFF with wstrb=4'b0101 -> read 0x00FF00FF.
REQ-035 Randomised run of 5000 ns with random rst_n, wen, ren, addresses and data against a behavioural model -> zero rdata/rvalid mismatches, checked every cycle.
